// File: rtl/bitlet_pkg.sv
// Shared sizing and helpers for the Bitlet exponent-alignment stage.
//   N   : lanes per vector (matches the max-exponent compare-tree input count)
//   EW  : exponent width (matches the compare-tree data width)
//   MW  : mantissa width per lane, hidden bit included
//   FD  : pending-vector FIFO depth (power of 2, >= $clog2(N)+1)
//   SHW : width of a clamped shift amount (0..MW)
package bitlet_pkg;

  localparam int N   = 16;
  localparam int EW  = 9;
  localparam int MW  = 24;
  localparam int FD  = 8;
  localparam int SHW = $clog2(MW + 1);
  localparam int PW  = $clog2(FD);     // FIFO pointer width
  localparam int CW  = PW + 1;         // FIFO occupancy width (0..FD)

  // Clamp an exponent difference to MW: shifting further than the mantissa
  // width only ever produces zero, so larger amounts need no extra encoding.
  function automatic logic [SHW-1:0] sat_shift(input logic [EW-1:0] diff);
    if (diff >= EW'(MW)) return SHW'(MW);
    else                 return diff[SHW-1:0];
  endfunction

endpackage

// File: rtl/bitlet_align_lane.sv
// One lane of the alignment shifter: purely combinational.
//   man   in  MW   lane mantissa
//   sh    in  SHW  right-shift amount, already clamped to 0..MW
//   man_o out MW   man >> sh
//   stk   out 1    OR of every bit shifted out of the bottom
module bitlet_align_lane
  import bitlet_pkg::*;
(
  input  logic [MW-1:0]  man,
  input  logic [SHW-1:0] sh,
  output logic [MW-1:0]  man_o,
  output logic           stk
);

  logic [MW-1:0] ones;
  logic [MW-1:0] lost_mask;

  assign ones      = '1;
  assign man_o     = man >> sh;
  // Low sh bits set; sh == MW shifts every one out, leaving a full mask.
  assign lost_mask = ~(ones << sh);
  assign stk       = |(man & lost_mask);

endmodule

// File: rtl/bitlet_exp_align.sv
// Exponent-alignment stage downstream of the Bitlet max-exponent compare tree.
// Each input vector is queued while the tree resolves its maximum exponent; the
// MAX result (which returns in issue order) pops the head, every lane mantissa
// is right-shifted by MAX - exp_i, and the aligned vector leaves two cycles later.
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   DI_vld/exp/man    input vector pulse, N lane exponents, N lane mantissas
//   MAX_vld/MAX       tree result pulse and max exponent of the oldest pending vector
//   ALN_vld/exp/man   aligned vector pulse, common exponent, aligned mantissas
//   ALN_stk           per-lane sticky (OR of bits shifted out)
//   ERR_ovf/ERR_unf   sticky flags: push while full / MAX_vld while empty
module bitlet_exp_align
  import bitlet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              DI_vld,
  input  logic [N*EW-1:0]   DI_exp,
  input  logic [N*MW-1:0]   DI_man,
  input  logic              MAX_vld,
  input  logic [EW-1:0]     MAX,
  output logic              ALN_vld,
  output logic [EW-1:0]     ALN_exp,
  output logic [N*MW-1:0]   ALN_man,
  output logic [N-1:0]      ALN_stk,
  output logic              ERR_ovf,
  output logic              ERR_unf
);

  // ---------------- pending-vector FIFO ----------------
  logic [N*EW-1:0] exp_mem [FD];
  logic [N*MW-1:0] man_mem [FD];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, do_pop, do_push;
  logic [N*EW-1:0] head_exp;
  logic [N*MW-1:0] head_man;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FD));
  assign do_pop   = MAX_vld & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = DI_vld & (~full | do_pop);
  assign head_exp = exp_mem[rd_ptr];
  assign head_man = man_mem[rd_ptr];

  // NOTE: storage is not reset; occupancy is governed solely by the reset
  // pointers/count, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      exp_mem[wr_ptr] <= DI_exp;
      man_mem[wr_ptr] <= DI_man;
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ERR_ovf <= 1'b0;
      ERR_unf <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (DI_vld & ~do_push) ERR_ovf <= 1'b1;
      if (MAX_vld & empty)   ERR_unf <= 1'b1;
    end
  end

  // ---------------- per-lane shift amount and shifter ----------------
  logic [N*SHW-1:0] sh_nxt;
  logic             a_vld;
  logic [EW-1:0]    a_max;
  logic [N*MW-1:0]  a_man;
  logic [N*SHW-1:0] a_sh;
  logic [N*MW-1:0]  lane_man;
  logic [N-1:0]     lane_stk;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [EW-1:0] e;
    logic [EW-1:0] diff;

    assign e    = head_exp[i*EW +: EW];
    // A lane above MAX breaks the tree's contract; leave it unshifted.
    assign diff = (e > MAX) ? '0 : EW'(MAX - e);
    assign sh_nxt[i*SHW +: SHW] = sat_shift(diff);

    bitlet_align_lane u_lane (
      .man   (a_man[i*MW +: MW]),
      .sh    (a_sh[i*SHW +: SHW]),
      .man_o (lane_man[i*MW +: MW]),
      .stk   (lane_stk[i])
    );
  end

  // ---------------- stage A: capture MAX, head mantissas, shift amounts ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vld <= 1'b0;
      a_max <= '0;
      a_man <= '0;
      a_sh  <= '0;
    end else begin
      a_vld <= do_pop;
      if (do_pop) begin
        a_max <= MAX;
        a_man <= head_man;
        a_sh  <= sh_nxt;
      end
    end
  end

  // ---------------- stage B: registered aligned outputs ----------------
  // Data registers only load on a valid, so ALN_* hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALN_vld <= 1'b0;
      ALN_exp <= '0;
      ALN_man <= '0;
      ALN_stk <= '0;
    end else begin
      ALN_vld <= a_vld;
      if (a_vld) begin
        ALN_exp <= a_max;
        ALN_man <= lane_man;
        ALN_stk <= lane_stk;
      end
    end
  end

endmodule

// File: tb/tb_bitlet_exp_align.sv
// Self-checking bench for bitlet_exp_align: a queue-based reference model of
// the pending vectors, a per-cycle compare process, and directed literal checks.
module tb_bitlet_exp_align;
  import bitlet_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              DI_vld;
  logic [N*EW-1:0]   DI_exp;
  logic [N*MW-1:0]   DI_man;
  logic              MAX_vld;
  logic [EW-1:0]     MAX;
  logic              ALN_vld;
  logic [EW-1:0]     ALN_exp;
  logic [N*MW-1:0]   ALN_man;
  logic [N-1:0]      ALN_stk;
  logic              ERR_ovf;
  logic              ERR_unf;

  bitlet_exp_align dut (
    .clk(clk), .rst(rst),
    .DI_vld(DI_vld), .DI_exp(DI_exp), .DI_man(DI_man),
    .MAX_vld(MAX_vld), .MAX(MAX),
    .ALN_vld(ALN_vld), .ALN_exp(ALN_exp), .ALN_man(ALN_man), .ALN_stk(ALN_stk),
    .ERR_ovf(ERR_ovf), .ERR_unf(ERR_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*EW-1:0] e;
    logic [N*MW-1:0] m;
  } vec_t;

  typedef struct packed {
    logic            vld;
    logic [EW-1:0]   ex;
    logic [N*MW-1:0] man;
    logic [N-1:0]    stk;
  } res_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [N*MW-1:0] act, input logic [N*MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Alignment straight from the arithmetic definition, using 64-bit integers.
  function automatic res_t align(input vec_t v, input logic [EW-1:0] mx);
    res_t r;
    r.vld = 1'b1;
    r.ex  = mx;
    r.man = '0;
    r.stk = '0;
    for (int i = 0; i < N; i++) begin
      longint unsigned e, m, d, sh;
      e  = longint'(v.e[i*EW +: EW]);
      m  = longint'(v.m[i*MW +: MW]);
      d  = (e > longint'(mx)) ? 0 : longint'(mx) - e;
      sh = (d > MW) ? MW : d;
      r.man[i*MW +: MW] = MW'(m >> sh);
      r.stk[i] = ((m & ((64'd1 << sh) - 64'd1)) != 0);
    end
    return r;
  endfunction

  vec_t q[$];
  res_t stage, held, r_new;
  vec_t pv;
  logic m_ovf, m_unf;

  // held = what ALN_* must show after this edge; stage = result one edge behind.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      stage = '0;
      held  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (stage.vld) held = stage;
      else           held.vld = 1'b0;
      r_new = '0;
      if (MAX_vld) begin
        if (q.size() == 0) m_unf = 1'b1;
        else               r_new = align(q.pop_front(), MAX);
      end
      if (DI_vld) begin
        if (q.size() < FD) begin
          pv.e = DI_exp;
          pv.m = DI_man;
          q.push_back(pv);
        end else begin
          m_ovf = 1'b1;
        end
      end
      stage = r_new;
    end
  end

  always @(negedge clk) begin
    check("aln_vld", N*MW'(ALN_vld), N*MW'(held.vld));
    check("aln_exp", N*MW'(ALN_exp), N*MW'(held.ex));
    check("aln_man", ALN_man, held.man);
    check("aln_stk", N*MW'(ALN_stk), N*MW'(held.stk));
    check("err_ovf", N*MW'(ERR_ovf), N*MW'(m_ovf));
    check("err_unf", N*MW'(ERR_unf), N*MW'(m_unf));
  end

  // ---------------- stimulus helpers (entered and left at posedge+1) --------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input vec_t v);
    DI_vld = 1'b1; DI_exp = v.e; DI_man = v.m;
    step();
    DI_vld = 1'b0;
  endtask

  task automatic pop(input logic [EW-1:0] mx);
    MAX_vld = 1'b1; MAX = mx;
    step();
    MAX_vld = 1'b0;
  endtask

  task automatic push_pop(input vec_t v, input logic [EW-1:0] mx);
    DI_vld = 1'b1; DI_exp = v.e; DI_man = v.m;
    MAX_vld = 1'b1; MAX = mx;
    step();
    DI_vld = 1'b0; MAX_vld = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) begin
      v.e[i*EW +: EW] = EW'($urandom_range(90, 140));
      v.m[i*MW +: MW] = {1'b1, 23'($urandom)};
    end
    return v;
  endfunction

  function automatic logic [EW-1:0] max_of(input vec_t v);
    logic [EW-1:0] mx = '0;
    for (int i = 0; i < N; i++)
      if (v.e[i*EW +: EW] > mx) mx = v.e[i*EW +: EW];
    return mx;
  endfunction

  vec_t v;
  vec_t burst[8];

  initial begin
    rst = 1'b1; DI_vld = 1'b0; DI_exp = '0; DI_man = '0; MAX_vld = 1'b0; MAX = '0;
    idle(3);
    check("reset_vld", N*MW'(ALN_vld), '0);
    check("reset_man", ALN_man, '0);
    @(posedge clk); #3 rst = 1'b0;
    step();

    // 1: staircase exponents, MAX = 115
    for (int i = 0; i < N; i++) begin
      v.e[i*EW +: EW] = EW'(100 + i);
      v.m[i*MW +: MW] = 24'h800001;
    end
    push(v);
    idle(3);
    pop(9'd115);
    step();
    check("t1_vld", N*MW'(ALN_vld), N*MW'(1));
    check("t1_exp", N*MW'(ALN_exp), N*MW'(115));
    check("t1_lane15", N*MW'(ALN_man[15*MW +: MW]), N*MW'(24'h800001));
    check("t1_lane0", N*MW'(ALN_man[0 +: MW]), N*MW'(24'h000100));
    check("t1_stk0", N*MW'(ALN_stk[0]), N*MW'(1));
    check("t1_stk15", N*MW'(ALN_stk[15]), N*MW'(0));

    // 2: eight back-to-back pushes then eight back-to-back MAX results
    for (int k = 0; k < 8; k++) begin
      burst[k] = rand_vec();
      push(burst[k]);
    end
    for (int k = 0; k < 8; k++) pop(max_of(burst[k]));
    idle(3);
    check("t2_ovf", N*MW'(ERR_ovf), '0);
    check("t2_unf", N*MW'(ERR_unf), '0);

    // 3: lane shifted fully out, and a lane above MAX left unshifted
    v = rand_vec();
    v.e[0 +: EW]  = 9'd0;   v.m[0 +: MW]  = 24'h123456;
    v.e[EW +: EW] = 9'd300; v.m[MW +: MW] = 24'hABCDEF;
    push(v);
    pop(9'd200);
    step();
    check("t3_lane0", N*MW'(ALN_man[0 +: MW]), '0);
    check("t3_stk0", N*MW'(ALN_stk[0]), N*MW'(1));
    check("t3_lane1", N*MW'(ALN_man[MW +: MW]), N*MW'(24'hABCDEF));
    check("t3_stk1", N*MW'(ALN_stk[1]), N*MW'(0));

    // 4: fill, push+pop at full (no error), then overflow
    for (int k = 0; k < FD; k++) begin
      burst[k] = rand_vec();
      push(burst[k]);
    end
    push_pop(rand_vec(), max_of(burst[0]));
    check("t4_ovf_clear", N*MW'(ERR_ovf), '0);
    push(rand_vec());
    check("t4_ovf_set", N*MW'(ERR_ovf), N*MW'(1));
    for (int k = 0; k < FD; k++) pop(9'(100 + k * 5));
    idle(3);

    // 5: MAX_vld with nothing pending
    check("t5_unf_clear", N*MW'(ERR_unf), '0);
    pop(9'd120);
    check("t5_unf_set", N*MW'(ERR_unf), N*MW'(1));
    step();
    check("t5_no_vld", N*MW'(ALN_vld), '0);

    // 6: reset with vectors pending and one in stage B
    for (int k = 0; k < 4; k++) push(rand_vec());
    pop(9'd140);
    step();
    #2 rst = 1'b1;
    #1;
    check("t6_vld", N*MW'(ALN_vld), '0);
    check("t6_exp", N*MW'(ALN_exp), '0);
    check("t6_man", ALN_man, '0);
    check("t6_errs", N*MW'({ERR_ovf, ERR_unf}), '0);
    @(posedge clk); #3 rst = 1'b0;
    step();
    idle(4);
    v = rand_vec();
    push(v);
    pop(max_of(v));
    idle(3);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      v = rand_vec();
      DI_vld  = ($urandom_range(0, 99) < 45);
      DI_exp  = v.e;
      DI_man  = v.m;
      MAX_vld = ($urandom_range(0, 99) < 42);
      MAX     = EW'($urandom_range(85, 170));
      step();
    end
    DI_vld = 1'b0; MAX_vld = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
